// File: rtl/queue_frame_writer.sv
// queue_frame_writer: pops 17-bit pixel/control words from the pixel queue,
// decodes frame/row/end markers, packs RGB565 pixel pairs into 32-bit words
// and writes them into one of two frame buffers through a valid/ready port.
// The displayable buffer index flips each time a frame completes.
module queue_frame_writer #(
   parameter int unsigned FRAME_WIDTH  = 480,
   parameter int unsigned FRAME_HEIGHT = 272,
   parameter int unsigned ADDR_WIDTH   = 21,
   parameter int unsigned BUF0_BASE    = 0,
   parameter int unsigned BUF1_BASE    = 65280
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  queue_empty,
   output logic                  queue_rd_en,
   input  logic [16:0]           queue_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  frame_done,
   output logic                  display_buffer,
   output logic                  format_error
);

   localparam logic [16:0] CTRL_FRAME_START = 17'h10000;
   localparam logic [16:0] CTRL_ROW_START   = 17'h10001;
   localparam logic [16:0] CTRL_FRAME_END   = 17'h1FFFF;

   localparam logic [10:0]           W_COUNT   = 11'(FRAME_WIDTH);
   localparam logic [10:0]           H_COUNT   = 11'(FRAME_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(FRAME_WIDTH / 2);
   localparam logic [ADDR_WIDTH-1:0] BASE0     = ADDR_WIDTH'(BUF0_BASE);
   localparam logic [ADDR_WIDTH-1:0] BASE1     = ADDR_WIDTH'(BUF1_BASE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_ROW,
      ST_ROW,
      ST_DONE
   } state_t;

   // Skid buffer storage and read-credit tracking
   logic [16:0] r_skid [2];
   logic        r_skid_wr_ptr;
   logic        r_skid_rd_ptr;
   logic [1:0]  r_skid_count;
   logic        r_in_flight;

   // Frame walker state
   state_t                r_state;
   logic [10:0]           r_row;
   logic [10:0]           r_col;
   logic [15:0]           r_half;
   logic                  r_half_vld;
   logic                  r_wr_buf;

   // Registered outputs
   logic                  r_wr_valid;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [31:0]           r_wr_data;
   logic                  r_frame_done;
   logic                  r_display_buffer;
   logic                  r_format_error;

   logic [16:0]           w_head;
   logic                  w_out_free;
   logic                  w_consume;
   logic [1:0]            w_space;
   logic                  w_is_fs;
   logic                  w_is_rs;
   logic                  w_is_fe;
   logic                  w_is_unknown;
   logic [15:0]           w_pixel;
   logic                  w_row_in_range;
   logic                  w_col_in_range;
   logic                  w_col_complete;
   logic [ADDR_WIDTH-1:0] w_buf_base;
   logic [ADDR_WIDTH-1:0] w_pair_addr;

   assign w_head       = r_skid[r_skid_rd_ptr];
   assign w_is_fs      = (w_head == CTRL_FRAME_START);
   assign w_is_rs      = (w_head == CTRL_ROW_START);
   assign w_is_fe      = (w_head == CTRL_FRAME_END);
   assign w_is_unknown = w_head[16] && !w_is_fs && !w_is_rs && !w_is_fe;
   assign w_pixel      = w_head[15:0];

   // A word is consumed only when the output register is free (or being
   // accepted this cycle); DONE holds the stream until the last write drains.
   assign w_out_free = !r_wr_valid || wr_ready;
   assign w_consume  = (r_skid_count != 2'd0) && w_out_free && (r_state != ST_DONE);

   // The slot freed by this cycle's consume counts as free, which is what
   // keeps back-to-back pops going at one word per cycle.
   assign w_space     = 2'd2 - r_skid_count - {1'b0, r_in_flight};
   assign queue_rd_en = reset_n && !queue_empty && ((w_space != 2'd0) || w_consume);

   assign w_row_in_range = (r_row < H_COUNT);
   assign w_col_in_range = (r_col < W_COUNT);
   assign w_col_complete = (r_col == W_COUNT);

   // Pair address: r_col is odd both when the odd pixel arrives and when a
   // lone even pixel is flushed, so col/2 selects the same word in both cases.
   assign w_buf_base  = r_wr_buf ? BASE1 : BASE0;
   assign w_pair_addr = w_buf_base + ADDR_WIDTH'(r_row) * ROW_PITCH
                        + ADDR_WIDTH'(r_col >> 1);

   assign wr_valid       = r_wr_valid;
   assign wr_addr        = r_wr_addr;
   assign wr_data        = r_wr_data;
   assign frame_done     = r_frame_done;
   assign display_buffer = r_display_buffer;
   assign format_error   = r_format_error;

   // Skid buffer: capture popped data one cycle after the pop, release in order
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_skid[0]     <= '0;
         r_skid[1]     <= '0;
         r_skid_wr_ptr <= 1'b0;
         r_skid_rd_ptr <= 1'b0;
         r_skid_count  <= '0;
         r_in_flight   <= 1'b0;
      end else begin
         r_in_flight <= queue_rd_en;
         if (r_in_flight) begin
            r_skid[r_skid_wr_ptr] <= queue_data;
            r_skid_wr_ptr         <= ~r_skid_wr_ptr;
         end
         if (w_consume) begin
            r_skid_rd_ptr <= ~r_skid_rd_ptr;
         end
         r_skid_count <= r_skid_count + {1'b0, r_in_flight} - {1'b0, w_consume};
      end
   end

   // Frame walker: decode markers, pack pixel pairs, drive the write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_row            <= '0;
         r_col            <= '0;
         r_half           <= '0;
         r_half_vld       <= 1'b0;
         r_wr_buf         <= 1'b0;
         r_wr_valid       <= 1'b0;
         r_wr_addr        <= '0;
         r_wr_data        <= '0;
         r_frame_done     <= 1'b0;
         r_display_buffer <= 1'b0;
         r_format_error   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (r_wr_valid && wr_ready) begin
            r_wr_valid <= 1'b0;
         end

         if (w_consume && w_is_fs) begin
            // FRAME_START anywhere restarts on the same buffer without flushing
            if (r_state != ST_IDLE) begin
               r_format_error <= 1'b1;
            end
            r_state    <= ST_WAIT_ROW;
            r_row      <= '0;
            r_col      <= '0;
            r_half_vld <= 1'b0;
         end else if (w_consume && w_is_unknown) begin
            r_format_error <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // pixels and row/end markers outside a frame are discarded
               end

               ST_WAIT_ROW: begin
                  if (w_consume) begin
                     if (w_is_rs) begin
                        r_state <= ST_ROW;
                        r_col   <= '0;
                     end else if (w_is_fe) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_format_error <= 1'b1;
                     end
                  end
               end

               ST_ROW: begin
                  if (w_consume) begin
                     if (w_is_rs || w_is_fe) begin
                        if (!w_col_complete) begin
                           r_format_error <= 1'b1;
                        end
                        if (r_half_vld) begin
                           r_wr_valid <= 1'b1;
                           r_wr_addr  <= w_pair_addr;
                           r_wr_data  <= {16'h0000, r_half};
                        end
                        r_half_vld <= 1'b0;
                        r_row      <= r_row + 11'd1;
                        r_col      <= '0;
                        r_state    <= w_is_rs ? ST_ROW : ST_DONE;
                     end else if (!w_row_in_range || !w_col_in_range) begin
                        r_format_error <= 1'b1;
                     end else if (!r_col[0]) begin
                        r_half     <= w_pixel;
                        r_half_vld <= 1'b1;
                        r_col      <= r_col + 11'd1;
                     end else begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= w_pair_addr;
                        r_wr_data  <= {w_pixel, r_half};
                        r_half_vld <= 1'b0;
                        r_col      <= r_col + 11'd1;
                     end
                  end
               end

               ST_DONE: begin
                  if (w_out_free) begin
                     r_frame_done     <= 1'b1;
                     r_display_buffer <= r_wr_buf;
                     r_wr_buf         <= ~r_wr_buf;
                     r_state          <= ST_IDLE;
                     if (r_row != H_COUNT) begin
                        r_format_error <= 1'b1;
                     end
                  end
               end

               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_queue_frame_writer.sv
// Bench for queue_frame_writer on a reduced 16x4 frame geometry.
// A stream-level model turns every pushed queue word into the ordered list
// of memory writes and frame completions it must cause; the DUT is checked
// against that list on every accepted write and every frame_done pulse.
module tb_queue_frame_writer;

   localparam int unsigned W  = 16;
   localparam int unsigned H  = 4;
   localparam int unsigned AW = 21;
   localparam int unsigned B0 = 0;
   localparam int unsigned B1 = 32;

   localparam logic [16:0] FS = 17'h10000;
   localparam logic [16:0] RS = 17'h10001;
   localparam logic [16:0] FE = 17'h1FFFF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          queue_empty = 1'b1;
   logic          queue_rd_en;
   logic [16:0]   queue_data = '0;
   logic          wr_valid;
   logic          wr_ready = 1'b0;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          frame_done;
   logic          display_buffer;
   logic          format_error;

   queue_frame_writer #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .ADDR_WIDTH  (AW),
      .BUF0_BASE   (B0),
      .BUF1_BASE   (B1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .queue_empty   (queue_empty),
      .queue_rd_en   (queue_rd_en),
      .queue_data    (queue_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .frame_done    (frame_done),
      .display_buffer(display_buffer),
      .format_error  (format_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_done;
      int unsigned addr;
      logic [31:0] data;
      bit          disp;
   } ev_t;

   ev_t         exp_q[$];
   logic [16:0] q_in[$];
   int unsigned acc_addr[$];
   logic [31:0] acc_data[$];
   int          n_done = 0;
   int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   // Stream model: 0 outside a frame, 1 awaiting a row, 2 inside a row
   int          m_st;
   int unsigned m_row, m_col;
   logic [15:0] m_half;
   bit          m_hv, m_wbuf;

   function automatic void model_reset();
      m_st = 0; m_row = 0; m_col = 0; m_half = '0; m_hv = 0; m_wbuf = 0;
   endfunction

   // A write covers pixels (2k, 2k+1) of the linear pixel index within the buffer
   function automatic void emit_write(input int unsigned row, input int unsigned col,
                                      input logic [31:0] data);
      ev_t e;
      e.is_done = 0;
      e.addr    = (m_wbuf ? B1 : B0) + (row * W + col) / 2;
      e.data    = data;
      e.disp    = 0;
      exp_q.push_back(e);
   endfunction

   function automatic void model_feed(input logic [16:0] w);
      ev_t e;
      if (w[16]) begin
         if (w == FS) begin
            m_st = 1; m_row = 0; m_col = 0; m_hv = 0;
         end else if (w == RS || w == FE) begin
            if (m_st != 0) begin
               if (m_st == 2) begin
                  if (m_hv) emit_write(m_row, m_col - 1, {16'h0000, m_half});
                  m_hv = 0;
                  m_row++;
               end
               if (w == RS) begin
                  m_st = 2; m_col = 0;
               end else begin
                  e.is_done = 1; e.addr = 0; e.data = '0; e.disp = m_wbuf;
                  exp_q.push_back(e);
                  m_wbuf = !m_wbuf;
                  m_st = 0;
               end
            end
         end
      end else if (m_st == 2 && m_row < H && m_col < W) begin
         if (m_col % 2 == 0) begin
            m_half = w[15:0]; m_hv = 1;
         end else begin
            emit_write(m_row, m_col - 1, {w[15:0], m_half});
            m_hv = 0;
         end
         m_col++;
      end
   endfunction

   task automatic push(input logic [16:0] w);
      q_in.push_back(w);
      model_feed(w);
   endtask

   // kind 0: colour bars two pixels wide; kind 1: 0x1000 + column
   task automatic push_row(input int n, input int kind);
      logic [16:0] w;
      for (int c = 0; c < n; c++) begin
         if (kind == 0) w = {1'b0, bars[c / 2]};
         else w = 17'(32'h1000 + 32'(c));
         push(w);
      end
   endtask

   task automatic push_frame();
      push(FS);
      for (int r = 0; r < int'(H); r++) begin
         push(RS);
         push_row(int'(W), 0);
      end
      push(FE);
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (q_in.size() == 0 && exp_q.size() == 0) break;
      end
      repeat (6) @(negedge clk);
      chk({name, "_pending"}, 64'(exp_q.size()), 64'(0));
      chk({name, "_queue"}, 64'(q_in.size()), 64'(0));
   endtask

   // Queue emulation: data appears one cycle after a sampled pop
   initial begin : feeder
      bit pop;
      forever begin
         @(negedge clk);
         pop = queue_rd_en && reset_n;
         @(posedge clk);
         #1;
         if (pop && q_in.size() > 0) queue_data = q_in.pop_front();
         queue_empty = (q_in.size() == 0);
         case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
         endcase
      end
   end

   // Per-cycle compare against the model's event list
   bit            prev_stall = 0;
   bit            prev_done  = 0;
   logic [AW-1:0] prev_addr;
   logic [31:0]   prev_data;

   always @(negedge clk) begin : compare
      ev_t e;
      bit  ok;
      if (!reset_n) begin
         prev_stall = 0;
         prev_done  = 0;
      end else begin
         chk("rd_en_when_empty", 64'(queue_rd_en && queue_empty), 64'(0));
         if (prev_stall) begin
            chk("hold_valid", 64'(wr_valid), 64'(1));
            chk("hold_addr", 64'(wr_addr), 64'(prev_addr));
            chk("hold_data", 64'(wr_data), 64'(prev_data));
         end
         if (wr_valid && wr_ready) begin
            ok = (exp_q.size() > 0) && !exp_q[0].is_done;
            chk("write_expected", 64'(ok), 64'(1));
            if (ok) begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(wr_addr), 64'(e.addr));
               chk("wr_data", 64'(wr_data), 64'(e.data));
            end
            acc_addr.push_back(int'(wr_addr));
            acc_data.push_back(wr_data);
         end
         if (frame_done) begin
            chk("done_pulse_width", 64'(prev_done), 64'(0));
            ok = (exp_q.size() > 0) && exp_q[0].is_done;
            chk("done_expected", 64'(ok), 64'(1));
            if (ok) begin
               e = exp_q.pop_front();
               chk("display_buffer", 64'(display_buffer), 64'(e.disp));
            end
            n_done++;
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
         prev_done  = frame_done;
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_valid"}, 64'(wr_valid), 64'(0));
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
      chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
      chk({tag, "_display"}, 64'(display_buffer), 64'(0));
      chk({tag, "_format_error"}, 64'(format_error), 64'(0));
      chk({tag, "_rd_en"}, 64'(queue_rd_en), 64'(0));
   endtask

   initial begin : main
      int pops;
      int done_snap;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;

      // One clean frame into buffer 0
      ready_mode = 0;
      acc_addr.delete(); acc_data.delete();
      push_frame();
      wait_drain("f1", 2000);
      chk("f1_writes", 64'(acc_addr.size()), 64'(32));
      chk("f1_first_addr", 64'(acc_addr[0]), 64'(0));
      chk("f1_first_data", 64'(acc_data[0]), 64'(32'hFFFF_FFFF));
      chk("f1_last_addr", 64'(acc_addr[31]), 64'(31));
      chk("f1_done_count", 64'(n_done), 64'(1));
      chk("f1_display", 64'(display_buffer), 64'(0));
      chk("f1_error", 64'(format_error), 64'(0));

      // Second frame lands in buffer 1, third back in buffer 0
      acc_addr.delete(); acc_data.delete();
      push_frame();
      wait_drain("f2", 2000);
      chk("f2_first_addr", 64'(acc_addr[0]), 64'(32));
      chk("f2_last_addr", 64'(acc_addr[31]), 64'(63));
      chk("f2_display", 64'(display_buffer), 64'(1));
      acc_addr.delete(); acc_data.delete();
      push_frame();
      wait_drain("f3", 2000);
      chk("f3_first_addr", 64'(acc_addr[0]), 64'(0));
      chk("f3_display", 64'(display_buffer), 64'(0));
      chk("f3_done_count", 64'(n_done), 64'(3));

      // Random back-pressure with the queue kept full
      ready_mode = 1;
      push_frame();
      push_frame();
      wait_drain("rand", 4000);
      chk("rand_done_count", 64'(n_done), 64'(5));
      chk("rand_error", 64'(format_error), 64'(0));

      // Hard stall: pops must stop once the skid is full
      ready_mode = 2;
      acc_addr.delete(); acc_data.delete();
      push_frame();
      repeat (12) @(negedge clk);
      pops = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (queue_rd_en) pops++;
      end
      chk("stall_no_pop", 64'(pops), 64'(0));
      chk("stall_valid", 64'(wr_valid), 64'(1));
      chk("stall_addr", 64'(wr_addr), 64'(32));
      chk("stall_data", 64'(wr_data), 64'(32'hFFFF_FFFF));
      ready_mode = 0;
      wait_drain("stall", 2000);
      chk("stall_display", 64'(display_buffer), 64'(1));

      // Short first row: lone pixel flushed with a zero upper half
      acc_addr.delete(); acc_data.delete();
      push(FS);
      push(RS);
      push_row(15, 1);
      for (int r = 1; r < int'(H); r++) begin
         push(RS);
         push_row(int'(W), 1);
      end
      push(FE);
      wait_drain("short", 2000);
      chk("short_writes", 64'(acc_addr.size()), 64'(32));
      chk("short_flush_addr", 64'(acc_addr[7]), 64'(7));
      chk("short_flush_data", 64'(acc_data[7]), 64'(32'h0000_100E));
      chk("short_next_addr", 64'(acc_addr[8]), 64'(8));
      chk("short_next_data", 64'(acc_data[8]), 64'(32'h1001_1000));
      chk("short_error", 64'(format_error), 64'(1));
      chk("short_done_count", 64'(n_done), 64'(7));

      // FRAME_START mid-frame: restart at row 0 of the same buffer
      acc_addr.delete(); acc_data.delete();
      done_snap = n_done;
      push(FS);
      push(RS); push_row(int'(W), 0);
      push(RS); push_row(int'(W), 0);
      push(RS); push_row(6, 0);
      push_frame();
      wait_drain("abort", 2000);
      chk("abort_writes", 64'(acc_addr.size()), 64'(51));
      chk("abort_last_old", 64'(acc_addr[18]), 64'(50));
      chk("abort_restart_addr", 64'(acc_addr[19]), 64'(32));
      chk("abort_restart_data", 64'(acc_data[19]), 64'(32'hFFFF_FFFF));
      chk("abort_done_delta", 64'(n_done - done_snap), 64'(1));
      chk("abort_display", 64'(display_buffer), 64'(1));

      // Reset while a write is stalled
      ready_mode = 2;
      push_frame();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_valid) break;
      end
      chk("rst_valid_seen", 64'(wr_valid), 64'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      q_in.delete();
      exp_q.delete();
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      ready_mode = 0;

      // Without FRAME_START nothing is written
      acc_addr.delete(); acc_data.delete();
      done_snap = n_done;
      push(RS);
      push_row(4, 0);
      push(FE);
      wait_drain("noframe", 500);
      chk("noframe_writes", 64'(acc_addr.size()), 64'(0));
      chk("noframe_done", 64'(n_done - done_snap), 64'(0));
      chk("noframe_error", 64'(format_error), 64'(0));

      push_frame();
      wait_drain("postrst", 2000);
      chk("postrst_writes", 64'(acc_addr.size()), 64'(32));
      chk("postrst_first_addr", 64'(acc_addr[0]), 64'(0));
      chk("postrst_display", 64'(display_buffer), 64'(0));
      chk("postrst_done", 64'(n_done - done_snap), 64'(1));
      chk("postrst_error", 64'(format_error), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
